// File: rtl/pcie_recv_pkg.sv
// Shared constants, state encoding and status decode for the pcie_recv receive path.
// Macro PCIE_RECV_DEST_CHECK_EN (used in pcie_recv.sv) enables the destination-bit check.
package pcie_recv_pkg;

  localparam int DATA_W = 6;
  localparam logic [1:0] UMBRAL_DEF = 2'd3;

  localparam int ERR_D0  = 0;
  localparam int ERR_D1  = 1;
  localparam int ERR_OUT = 2;

  // Bit of each word that identifies its destination port when checking is enabled.
  localparam int DEST_BIT = 4;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_t;

  // {active, idle, error} flags for a given state.
  function automatic logic [2:0] status_of(state_t s);
    return {s == ST_ACTIVE, s == ST_IDLE, s == ST_ERROR};
  endfunction

endpackage

// File: rtl/pcie_recv_if.sv
// Link-side push streams, backpressure and consumer pop/data bundle for pcie_recv.
// master = link sender and consumer, slave = the receiver.
interface pcie_recv_if;
  import pcie_recv_pkg::*;

  logic [DATA_W-1:0] data_in0;
  logic              valid_in0;
  logic [DATA_W-1:0] data_in1;
  logic              valid_in1;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              pausa_D0;
  logic              pausa_D1;

  modport master (
    output data_in0, valid_in0, data_in1, valid_in1, pop,
    input  data_out, valid_out, pausa_D0, pausa_D1
  );

  modport slave (
    input  data_in0, valid_in0, data_in1, valid_in1, pop,
    output data_out, valid_out, pausa_D0, pausa_D1
  );

endinterface

// File: rtl/pcie_recv_rx_fifo.sv
// Synchronous FIFO with count/full/empty; push on full is accepted when a pop happens the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pcie_recv.sv
// Receive path: two input FIFOs with threshold pause, round-robin merge into an output FIFO, control FSM.
// Define PCIE_RECV_DEST_CHECK_EN to drop words whose destination bit does not match their port.
module pcie_recv #(
  parameter int DATA_W    = pcie_recv_pkg::DATA_W,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          init,
  input  logic [1:0]    umbral_D0,
  input  logic [1:0]    umbral_D1,
  pcie_recv_if.slave    bus,
  output logic          active_out,
  output logic          idle_out,
  output logic          error_out,
  output logic [2:0]    error_full
);
  import pcie_recv_pkg::*;

  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  state_t             state;
  logic [1:0]         umb0, umb1, umb0_nxt, umb1_nxt;
  logic               last_d1;
  logic [DATA_W-1:0]  head0, head1, out_head, xfer_data;
  logic [ICW-1:0]     cnt0, cnt1, nxt_cnt0, nxt_cnt1;
  logic [OCW-1:0]     cnt_o;
  logic               full0, full1, full_o, empty0, empty1, empty_o;
  logic               in_err, out_pop, out_space, grant0, grant1, xfer;
  logic               bad0, bad1, req0, req1, acc0, acc1, ovf0, ovf1, dest_err;
  logic               any_ne;

`ifdef PCIE_RECV_DEST_CHECK_EN
  assign bad0 = bus.data_in0[DEST_BIT] != 1'b0;
  assign bad1 = bus.data_in1[DEST_BIT] != 1'b1;
`else
  assign bad0 = 1'b0;
  assign bad1 = 1'b0;
`endif

  assign in_err    = (state == ST_ERROR);
  assign out_pop   = bus.pop && !empty_o;
  assign out_space = !full_o || out_pop;

  // When both inputs have data, the port not granted last time wins.
  assign grant0    = out_space && !empty0 && (empty1 || last_d1);
  assign grant1    = out_space && !empty1 && (empty0 || !last_d1);
  assign xfer      = grant0 || grant1;
  assign xfer_data = grant0 ? head0 : head1;

  assign req0     = bus.valid_in0 && !in_err && !bad0;
  assign req1     = bus.valid_in1 && !in_err && !bad1;
  assign acc0     = req0 && (!full0 || grant0);
  assign acc1     = req1 && (!full1 || grant1);
  assign ovf0     = req0 && full0 && !grant0;
  assign ovf1     = req1 && full1 && !grant1;
  assign dest_err = !in_err && ((bus.valid_in0 && bad0) || (bus.valid_in1 && bad1));

  assign nxt_cnt0 = cnt0 + ICW'(acc0) - ICW'(grant0);
  assign nxt_cnt1 = cnt1 + ICW'(acc1) - ICW'(grant1);
  assign umb0_nxt = (state == ST_INIT) ? umbral_D0 : umb0;
  assign umb1_nxt = (state == ST_INIT) ? umbral_D1 : umb1;
  assign any_ne   = !empty0 || !empty1 || (cnt_o != '0);

  rx_fifo #(.DEPTH(IN_DEPTH), .W(DATA_W)) u_fifo_d0 (
    .clk(clk), .reset_L(reset_L), .push(acc0), .pop(grant0), .din(bus.data_in0),
    .dout(head0), .count(cnt0), .full(full0), .empty(empty0)
  );

  rx_fifo #(.DEPTH(IN_DEPTH), .W(DATA_W)) u_fifo_d1 (
    .clk(clk), .reset_L(reset_L), .push(acc1), .pop(grant1), .din(bus.data_in1),
    .dout(head1), .count(cnt1), .full(full1), .empty(empty1)
  );

  rx_fifo #(.DEPTH(OUT_DEPTH), .W(DATA_W)) u_fifo_out (
    .clk(clk), .reset_L(reset_L), .push(xfer), .pop(bus.pop), .din(xfer_data),
    .dout(out_head), .count(cnt_o), .full(full_o), .empty(empty_o)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      umb0          <= UMBRAL_DEF;
      umb1          <= UMBRAL_DEF;
      last_d1       <= 1'b1;
      bus.pausa_D0  <= 1'b0;
      bus.pausa_D1  <= 1'b0;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      error_full    <= '0;
    end else begin
      umb0          <= umb0_nxt;
      umb1          <= umb1_nxt;
      if (grant0)      last_d1 <= 1'b0;
      else if (grant1) last_d1 <= 1'b1;
      bus.pausa_D0  <= nxt_cnt0 >= ICW'(umb0_nxt);
      bus.pausa_D1  <= nxt_cnt1 >= ICW'(umb1_nxt);
      if (out_pop) bus.data_out <= out_head;
      bus.valid_out <= out_pop;
      error_full[ERR_D0]  <= error_full[ERR_D0]  | ovf0;
      error_full[ERR_D1]  <= error_full[ERR_D1]  | ovf1;
      error_full[ERR_OUT] <= error_full[ERR_OUT] | dest_err;
    end
  end

  // state  | meaning
  // RESET  | first cycle after reset release
  // INIT   | thresholds track the umbral inputs
  // IDLE   | all FIFOs empty
  // ACTIVE | at least one FIFO holds data
  // ERROR  | overflow or bad destination seen; left only through reset
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state                               <= ST_RESET;
      {active_out, idle_out, error_out}   <= 3'b000;
    end else begin
      case (state)
        ST_RESET: begin
          state                             <= ST_INIT;
          {active_out, idle_out, error_out} <= status_of(ST_INIT);
        end
        ST_ERROR: begin
          state                             <= ST_ERROR;
          {active_out, idle_out, error_out} <= status_of(ST_ERROR);
        end
        default: begin
          if (ovf0 || ovf1 || dest_err) begin
            state                             <= ST_ERROR;
            {active_out, idle_out, error_out} <= status_of(ST_ERROR);
          end else if (init) begin
            state                             <= ST_INIT;
            {active_out, idle_out, error_out} <= status_of(ST_INIT);
          end else if (state != ST_INIT && any_ne) begin
            state                             <= ST_ACTIVE;
            {active_out, idle_out, error_out} <= status_of(ST_ACTIVE);
          end else begin
            state                             <= ST_IDLE;
            {active_out, idle_out, error_out} <= status_of(ST_IDLE);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_recv.sv
// Directed bench for pcie_recv: reset/init, single transfer, round-robin order, pause, overflow, dest check.
module tb_pcie_recv;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       init;
  logic [1:0] umbral_D0;
  logic [1:0] umbral_D1;
  logic       active_out;
  logic       idle_out;
  logic       error_out;
  logic [2:0] error_full;

  int n_tests = 0;
  int n_fail  = 0;

  pcie_recv_if bus ();

  pcie_recv dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .init       (init),
    .umbral_D0  (umbral_D0),
    .umbral_D1  (umbral_D1),
    .bus        (bus),
    .active_out (active_out),
    .idle_out   (idle_out),
    .error_out  (error_out),
    .error_full (error_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] flags();
    return {5'd0, active_out, idle_out, error_out};
  endfunction

  task automatic do_reset(input logic [1:0] u0, input logic [1:0] u1);
    reset_L       = 1'b0;
    init          = 1'b1;
    umbral_D0     = u0;
    umbral_D1     = u1;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    bus.pop       = 1'b0;
    tick();
    tick();
    reset_L = 1'b1;
    tick();
    tick();
    init = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] rr_exp [6];
    rr_exp = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13};

    reset_L       = 1'b0;
    init          = 1'b1;
    umbral_D0     = 2'd2;
    umbral_D1     = 2'd3;
    bus.data_in0  = '0;
    bus.data_in1  = '0;
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    bus.pop       = 1'b0;

    // reset values
    tick();
    chk("rst_data_out", 8'(bus.data_out), 8'h00);
    chk("rst_valid_out", 8'(bus.valid_out), 8'h00);
    chk("rst_pausa", {6'd0, bus.pausa_D1, bus.pausa_D0}, 8'h00);
    chk("rst_flags", flags(), 8'h00);
    chk("rst_error_full", 8'(error_full), 8'h00);

    reset_L = 1'b1;
    tick();
    chk("init_flags", flags(), 8'h00);
    tick();
    chk("init_hold_flags", flags(), 8'h00);
    init = 1'b0;
    tick();
    chk("idle_flags", flags(), 8'b010);
    chk("idle_pausa", {6'd0, bus.pausa_D1, bus.pausa_D0}, 8'h00);
    chk("idle_valid_out", 8'(bus.valid_out), 8'h00);

    // single word, two-cycle latency
    bus.data_in0  = 6'h05;
    bus.valid_in0 = 1'b1;
    tick();
    bus.valid_in0 = 1'b0;
    bus.pop       = 1'b1;
    tick();
    chk("single_active", flags(), 8'b100);
    chk("single_early_valid", 8'(bus.valid_out), 8'h00);
    tick();
    chk("single_valid", 8'(bus.valid_out), 8'h01);
    chk("single_data", 8'(bus.data_out), 8'h05);
    tick();
    chk("empty_pop_valid", 8'(bus.valid_out), 8'h00);
    chk("empty_pop_hold", 8'(bus.data_out), 8'h05);
    chk("back_to_idle", flags(), 8'b010);
    bus.pop = 1'b0;

    // round robin with both ports pushing
    do_reset(2'd3, 2'd3);
    bus.pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_in0  = 6'(8'h01 + i);
      bus.data_in1  = 6'(8'h11 + i);
      bus.valid_in0 = 1'b1;
      bus.valid_in1 = 1'b1;
      tick();
    end
    bus.valid_in0 = 1'b0;
    bus.valid_in1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rr_valid", 8'(bus.valid_out), 8'h01);
      chk("rr_data", 8'(bus.data_out), rr_exp[i]);
      tick();
    end
    chk("rr_done_valid", 8'(bus.valid_out), 8'h00);
    bus.pop = 1'b0;

    // pause threshold and D0 overflow
    do_reset(2'd2, 2'd3);
    for (int i = 1; i <= 12; i++) begin
      bus.data_in0  = 6'(i);
      bus.valid_in0 = 1'b1;
      tick();
      if (i == 9)  chk("pausa_below", 8'(bus.pausa_D0), 8'h00);
      if (i == 10) chk("pausa_rise", 8'(bus.pausa_D0), 8'h01);
    end
    chk("full_no_error", 8'(error_full), 8'h00);
    chk("full_active", flags(), 8'b100);
    chk("pausa_d1_low", 8'(bus.pausa_D1), 8'h00);
    bus.data_in0 = 6'h0D;
    tick();
    bus.valid_in0 = 1'b0;
    chk("ovf_error_full", 8'(error_full), 8'b001);
    chk("ovf_flags", flags(), 8'b001);
    bus.pop = 1'b1;
    tick();
    chk("err_pop1_valid", 8'(bus.valid_out), 8'h01);
    chk("err_pop1_data", 8'(bus.data_out), 8'h01);
    tick();
    chk("err_pop2_data", 8'(bus.data_out), 8'h02);
    init = 1'b1;
    tick();
    chk("err_sticky_flags", flags(), 8'b001);
    chk("err_sticky_full", 8'(error_full), 8'b001);
    reset_L = 1'b0;
    #2;
    chk("async_rst_full", 8'(error_full), 8'h00);
    chk("async_rst_flags", flags(), 8'h00);
    chk("async_rst_valid", 8'(bus.valid_out), 8'h00);
    chk("async_rst_data", 8'(bus.data_out), 8'h00);

    // umbral 0 keeps pausa asserted
    do_reset(2'd3, 2'd0);
    chk("umbral0_pausa_d1", 8'(bus.pausa_D1), 8'h01);
    chk("umbral3_pausa_d0", 8'(bus.pausa_D0), 8'h00);

    // destination bit on D0
    bus.data_in0  = 6'h10;
    bus.valid_in0 = 1'b1;
    tick();
    bus.valid_in0 = 1'b0;
    bus.pop       = 1'b1;
`ifdef PCIE_RECV_DEST_CHECK_EN
    chk("dest_error_full", 8'(error_full), 8'b100);
    chk("dest_flags", flags(), 8'b001);
    tick();
    tick();
    chk("dest_dropped", 8'(bus.valid_out), 8'h00);
`else
    chk("dest_error_full", 8'(error_full), 8'h00);
    tick();
    tick();
    chk("dest_valid", 8'(bus.valid_out), 8'h01);
    chk("dest_data", 8'(bus.data_out), 8'h10);
`endif
    bus.pop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_recv.md
# pcie_recv

Receive-side counterpart of the PCIe transmit path. It accepts the two destination streams (D0, D1) from the link, buffers each in a small input FIFO with threshold-based backpressure, and merges them with a round-robin arbiter into one output FIFO that the consumer pops. A RESET/INIT/IDLE/ACTIVE/ERROR control FSM mirrors the transmitter's control model.

## Interface
Parameters:
- DATA_W, 6, word width
- IN_DEPTH, 4, input FIFO depth per destination (count width 3)
- OUT_DEPTH, 8, output FIFO depth (count width 4)

Ports:
- clk  in  1  single clock, all state on posedge
- reset_L  in  1  reset, asynchronous, active-low
- init  in  1  forces INIT; umbrales are writable only in INIT
- umbral_D0  in  2  D0 pause threshold, latched in INIT
- umbral_D1  in  2  D1 pause threshold, latched in INIT
- data_in0  in  6  D0 word
- valid_in0  in  1  D0 push
- data_in1  in  6  D1 word
- valid_in1  in  1  D1 push
- pop  in  1  consumer pop of output FIFO
- data_out  out  6  popped word, registered
- valid_out  out  1  data_out valid, one cycle per accepted pop
- pausa_D0  out  1  backpressure to D0 sender
- pausa_D1  out  1  backpressure to D1 sender
- active_out  out  1  1 only in ACTIVE
- idle_out  out  1  1 only in IDLE
- error_out  out  1  1 only in ERROR
- error_full  out  3  sticky overflow ID, one bit per FIFO: {OUT, D1, D0}

## Operation
- Reset values: data_out=0, valid_out=0, pausa_D0/D1=0, active/idle/error_out=0, error_full=0. FIFOs are emptied and umbral registers are set to 2'd3. State is RESET.
- FSM:
  - RESET → INIT on the first clock after reset is released.
  - INIT: umbral registers load from the inputs every cycle. Go to IDLE when init=0.
  - IDLE → ACTIVE when any FIFO is non-empty.
  - ACTIVE → IDLE when all FIFOs are empty.
  - init=1 from IDLE or ACTIVE → INIT. INIT has precedence over IDLE/ACTIVE transitions.
  - Any overflow in INIT/IDLE/ACTIVE → ERROR.
  - ERROR is exited only by reset.
- Push: valid_inN=1 writes data_inN into input FIFO N.
  - A write to a full FIFO drops the word and sets error_full[N], unless the arbiter drains that FIFO in the same cycle; in that case the write is accepted with no error.
  - In ERROR, all pushes are ignored.
- Pausa: pausa_DN = (countN ≥ umbral_DN), registered from the next count so it updates on the same edge as the count. umbral 0 means pausa is always asserted.
- Arbiter: moves at most one word per cycle from an input head to the output FIFO, only when the output is not full (or is popped the same cycle).
  - Only one input non-empty: grant it.
  - Both non-empty: grant the opposite of the last grant. The last-grant register resets to D1, so D0 wins first.
- Output FIFO overflow cannot occur by construction. error_full[2] is reserved and is set only by the checker (see Configuration).
- Pop: pop with the output FIFO non-empty loads data_out and sets valid_out=1 for one cycle. Pop on empty is ignored: valid_out=0, data_out holds, no error. Pops are serviced in every state, including ERROR.

## Timing
- valid_inN at edge k → word in input FIFO after k → transferred at edge k+1 → poppable at edge k+2, with data_out/valid_out updating on that edge. Minimum input-to-output latency is 2 cycles plus the pop.
- Throughput is one word per cycle out, even with both inputs active.
- The sender reacts to pausa one cycle late. Umbral ≤ 3 leaves at least one slot of margin.
- Reset asserted mid-traffic: all contents are discarded immediately and outputs return to reset values asynchronously.

## Configuration
- PCIE_RECV_DEST_CHECK_EN defined: each accepted word's bit 4 must match its port (0 for D0, 1 for D1).
  - A mismatched word is dropped, sets error_full[2], and drives the FSM to ERROR.
- Not defined: no check; all words are accepted, and error_full[2] stays 0.

## Structure
- Package pcie_recv_pkg holds:
  - state encoding: RESET, INIT, IDLE, ACTIVE, ERROR
  - DATA_W
  - default umbral 2'd3
  - error_full bit indices
- Sub-module rx_fifo is parameterized by depth. It provides count, full, empty, and accepts simultaneous push/pop. It is instantiated three times.
- The arbiter and FSM live in pcie_recv.

## Test plan
- Reset, init=1 with umbral_D0=2, then init=0 → state goes RESET→INIT→IDLE; idle_out=1, all other outputs 0.
- Push 6'h05 on D0 at edge k, pop at k+2 → data_out=6'h05, valid_out=1 at k+2; FSM goes ACTIVE then IDLE.
- Both ports push continuously (D0 words 0x01.., D1 words 0x11..), pop every cycle → output order 0x01, 0x11, 0x02, 0x12, …
- umbral_D0=2, no pops, output FIFO full → pausa_D0 rises on the edge where D0 count reaches 2.
- Fill D0 to 4 with the output full, then a 5th push → word dropped, error_full=3'b001, error_out=1 next cycle; pops still drain; only reset clears it.
- With PCIE_RECV_DEST_CHECK_EN: push 6'h10 on D0 → dropped, error_full=3'b100, ERROR. Without the macro: the word is delivered.
